mul16s_arb_ctrl: RTL
====================

MUL16S_ARB_CTRL -- requirements
Module: mul16s_arb_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  16*NREQ  signed operand A, requester i in bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  16*NREQ  signed operand B, same packing.
REQ-009 SHALL have port approx_en  input  1  1 = approximate product, 0 = exact; sampled at handshake.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_data  output  32  signed product.
REQ-013 SHALL have port rsp_id  output  clog2(NREQ)  index of originating requester.

Function
REQ-014 SHALL grant round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a completed handshake.
REQ-015 SHALL assert req_ready[i] only when i is the winner among valid requesters and credit is available; req_ready may depend combinationally on req_valid.
REQ-016 SHALL define credit available as (fifo_count + inflight) < FIFO_DEPTH, inflight = 0..2 operations in pipeline.
REQ-017 SHALL, on handshake in cycle t, register operands, id, approx_en at end of t (stage 1), register product at end of t+1 (stage 2), write FIFO at end of t+2; rsp_valid high from t+3 if FIFO was empty.
REQ-018 SHALL sustain one accepted request per cycle while credit holds.
REQ-019 SHALL compute approximate product as signed(A[15:2]) * signed(B[15:2]) giving 28 bits, then output {product28, 4'b0011}.
REQ-020 SHALL compute exact product as full 32-bit signed A*B.
REQ-021 SHALL deliver results in acceptance order via FIFO; pop on rsp_valid & rsp_ready.
REQ-022 SHALL hold rsp_data/rsp_id stable while rsp_valid & !rsp_ready.
REQ-023 SHALL allow simultaneous FIFO push and pop when full or empty-with-bypass-free semantics: push and pop in same cycle leaves count unchanged; full FIFO never overflows because of REQ-016.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-025 SHALL ignore req_a/req_b/approx_en when no handshake occurs.

Reset
REQ-026 SHALL, on reset assertion, immediately clear FIFO, pipeline valids, inflight, and set last_grant = NREQ-1, so requester 0 has first priority.
REQ-027 SHALL drive req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0 while reset is high.
REQ-028 SHALL discard in-flight and buffered results when reset asserts mid-operation, with no response emitted afterwards.

Structure
REQ-029 SHALL place NREQ default, FIFO_DEPTH default, ID width function, and constant APPROX_LSB = 4'b0011 in package mul16s_arb_pkg.
REQ-030 SHALL instantiate one sub-module mul16s_approx_stage, a two-stage registered signed multiplier with approx_en select.

Verification
REQ-031 SHALL verify: approx_en=1, req0 A=0x0004 B=0x0004 -> rsp_data=0x00000013, rsp_id=0, rsp_valid exactly 3 cycles after handshake.
REQ-032 SHALL verify: approx_en=1, A=0xFFFC B=0x0004 -> 0xFFFFFFF3; A=0x0003 B=0x0003 -> 0x00000003; approx_en=0 same -> 0x00000009.
REQ-033 SHALL verify: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, rsp_id sequence matches.
REQ-034 SHALL verify: rsp_ready=0, continuous requests -> exactly 4 accepted, req_ready=0 thereafter; raising rsp_ready drains 4 results in order and resumes acceptance.
REQ-035 SHALL verify: reset asserted with 2 in flight and 2 buffered -> outputs zero same cycle; after release no stale rsp_valid, first grant to requester 0.

Source files
------------

// File: rtl/mul16s_arb_pkg.sv
// Shared constants and helpers for the arbitrated 16x16 signed multiplier.
package mul16s_arb_pkg;

    localparam int NREQ_DEFAULT       = 4;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Fixed low nibble appended to every approximate product.
    localparam logic [3:0] APPROX_LSB = 4'b0011;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul16s_approx_stage.sv
// Two-stage registered signed multiplier: operands latch in stage 1,
// the exact or approximate product latches in stage 2.
module mul16s_approx_stage
    import mul16s_arb_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [15:0] in_a,
    input  logic signed [15:0] in_b,
    input  logic               in_approx,
    input  logic [ID_W-1:0]    in_id,
    output logic               s1_valid,
    output logic               out_valid,
    output logic [31:0]        out_data,
    output logic [ID_W-1:0]    out_id
);

    logic signed [15:0] s1_a;
    logic signed [15:0] s1_b;
    logic               s1_approx;
    logic [ID_W-1:0]    s1_id;
    logic signed [27:0] approx_p;
    logic signed [31:0] exact_p;
    logic [31:0]        product;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_approx <= in_approx;
            s1_id     <= in_id;
        end
        if (s1_valid) begin
            out_data <= product;
            out_id   <= s1_id;
        end
    end

    always_comb begin
        approx_p = $signed(s1_a[15:2]) * $signed(s1_b[15:2]);
        exact_p  = s1_a * s1_b;
        product  = s1_approx ? {approx_p, APPROX_LSB} : exact_p;
    end

endmodule

// File: rtl/mul16s_arb_ctrl.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters,
// with a credit-limited in-order result FIFO.
module mul16s_arb_ctrl
    import mul16s_arb_pkg::*;
#(
    parameter  int NREQ       = NREQ_DEFAULT,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int ID_W       = id_width(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic                 approx_en,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id
);

    localparam int PTR_W = id_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             credit;
    logic             accept;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [1:0]       inflight;

    logic             s1_valid;
    logic             s2_valid;
    logic [31:0]      s2_data;
    logic [ID_W-1:0]  s2_id;

    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]  fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;

    // Credit counts results still owed to the FIFO, so a full FIFO is never pushed.
    assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid};
    assign credit   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign accept   = found && credit && !reset;

    // NOTE: every always_comb output is defaulted first so no latch is inferred.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(last_grant) + 1 + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (winner == ID_W'(k)) begin
                sel_a = req_a[16*k +: 16];
                sel_b = req_b[16*k +: 16];
            end
        end
        req_ready[winner] = accept;
    end

    mul16s_approx_stage #(.ID_W(ID_W)) u_mul (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (accept),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_approx (approx_en),
        .in_id     (winner),
        .s1_valid  (s1_valid),
        .out_valid (s2_valid),
        .out_data  (s2_data),
        .out_id    (s2_id)
    );

    assign push      = s2_valid;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]   : '0;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= ID_W'(NREQ - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                last_grant <= winner;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= s2_data;
            fifo_id[wr_ptr]   <= s2_id;
        end
    end

endmodule
